// File: rtl/xor_arbiter.sv
// xor_arbiter: NUM_REQ requesters share one per-bit XOR datapath.
// Define XOR_ARBITER_FIXED_PRIO_EN for fixed priority instead of round-robin.

module xor_module (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic            load_en;
  logic            any;
  logic [ID_W-1:0] gnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] xor_y;

`ifndef XOR_ARBITER_FIXED_PRIO_EN
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
`endif

  // Output register can take a new result when empty or being drained
  assign load_en = (state == EMPTY) || res_ready;

`ifdef XOR_ARBITER_FIXED_PRIO_EN
  // Fixed priority: lowest valid index wins (last assignment wins)
  always_comb begin
    any = 1'b0;
    gnt = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        any = 1'b1;
        gnt = ID_W'(k);
      end
    end
  end
`else
  // Round-robin: first valid index at or after ptr, wrapping
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    any  = 1'b0;
    gnt  = '0;
    idx  = 0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx  = (int'(ptr) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (req_valid[cand]) begin
        any = 1'b1;
        gnt = cand;
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NUM_REQ-1
  always_comb begin
    ptr_nxt = gnt + 1'b1;
    if (int'(gnt) == NUM_REQ - 1) begin
      ptr_nxt = '0;
    end
  end
`endif

  // One-hot ready to the winner; held off while in reset
  always_comb begin
    req_ready = '0;
    if (rst_n && load_en && any) begin
      req_ready[gnt] = 1'b1;
    end
  end

  assign op_a = req_a[int'(gnt)*WIDTH +: WIDTH];
  assign op_b = req_b[int'(gnt)*WIDTH +: WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_xor
    xor_module u_xor (
      .a(op_a[i]),
      .b(op_b[i]),
      .y(xor_y[i])
    );
  end

  // Result register FSM: load on transfer, empty when drained with no request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
`ifndef XOR_ARBITER_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else if (load_en) begin
      if (any) begin
        state     <= FULL;
        res_valid <= 1'b1;
        res_data  <= xor_y;
        res_id    <= gnt;
`ifndef XOR_ARBITER_FIXED_PRIO_EN
        ptr       <= ptr_nxt;
`endif
      end else begin
        state     <= EMPTY;
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xor_arbiter.sv
// tb_xor_arbiter: scoreboard bench for xor_arbiter (NUM_REQ=4, WIDTH=8).
// Expected results are queued at grant time and popped one cycle later.

module tb_xor_arbiter;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic [1:0]  res_id;

  exp_t sb[$];
  exp_t e;
  exp_t last;
  int   m_ptr;
  bit   m_full;
  bit   loaded;
  int   checks;
  int   fails;

  xor_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_id(res_id)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant(logic [3:0] v, int p);
`ifdef XOR_ARBITER_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      if (v[k]) return k;
    end
    if (p < 0) return -1;
`else
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
`endif
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant(req_valid, m_ptr);
    if (!rst_n || (m_full && !res_ready) || g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  // Push the expected result, take one clock edge, update the model
  task automatic advance();
    int   g;
    logic le;
    g      = exp_grant(req_valid, m_ptr);
    le     = !m_full || res_ready;
    loaded = 1'b0;
    if (rst_n && le && g >= 0) begin
      sb.push_back('{id: g, data: req_a[g*8 +: 8] ^ req_b[g*8 +: 8]});
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ptr  = 0;
      m_full = 1'b0;
    end else if (le) begin
      if (g >= 0) begin
        m_full = 1'b1;
        loaded = 1'b1;
`ifndef XOR_ARBITER_FIXED_PRIO_EN
        m_ptr  = (g + 1) % 4;
`endif
      end else begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    req_a     = 32'h1234_5678;
    req_b     = 32'h9abc_def0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      advance();
    end
    checks++;
    if (res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_out: got v=%b d=%h id=%0d want 0 00 0",
               res_valid, res_data, res_id);
    end
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    advance();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_a     = 32'h00A5_0000;
    req_b     = 32'h000F_0000;
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100 || req_ready !== exp_ready()) begin
      fails++;
      $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    advance();
    e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 8'hAA || res_id !== 2'd2
        || res_data !== e.data) begin
      fails++;
      $display("FAIL single_res: got v=%b d=%h id=%0d want 1 aa 2",
               res_valid, res_data, res_id);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    req_a     = 32'h3C96_5AF0;
    req_b     = 32'h8142_2418;
    req_valid = 4'b1000;
    #1;
    advance();
    if (loaded) void'(sb.pop_front());
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        fails++;
        $display("FAIL rr_ready%0d: got %b want %b", c, req_ready, exp_ready());
      end
      advance();
      e = sb.pop_front();
      checks++;
      if (res_valid !== 1'b1 || res_data !== e.data || res_id !== 2'(e.id)) begin
        fails++;
        $display("FAIL rr_res%0d: got v=%b d=%h id=%0d want d=%h id=%0d",
                 c, res_valid, res_data, res_id, e.data, e.id);
      end
`ifndef XOR_ARBITER_FIXED_PRIO_EN
      checks++;
      if (res_id !== 2'(seq[c])) begin
        fails++;
        $display("FAIL rr_seq%0d: got id=%0d want %0d", c, res_id, seq[c]);
      end
`endif
    end
    last      = e;
    req_valid = 4'b0000;
    #1;
    advance();
    checks++;
    if (res_valid !== 1'b0 || res_data !== last.data) begin
      fails++;
      $display("FAIL rr_drain: got v=%b d=%h want 0 %h",
               res_valid, res_data, last.data);
    end
  endtask

  task automatic test_backpressure();
    req_a     = 32'h55AA_F00F;
    req_b     = 32'h0FF0_3CC3;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    advance();
    last = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== last.data || res_id !== 2'(last.id)) begin
      fails++;
      $display("FAIL bp_first: got d=%h id=%0d want d=%h id=%0d",
               res_data, res_id, last.data, last.id);
    end
`ifndef XOR_ARBITER_FIXED_PRIO_EN
    checks++;
    if (res_id !== 2'd1) begin
      fails++;
      $display("FAIL bp_first_id: got %0d want 1", res_id);
    end
`endif
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready);
      end
      advance();
      checks++;
      if (res_valid !== 1'b1 || res_data !== last.data || res_id !== 2'(last.id)) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d want 1 %h %0d",
                 c, res_valid, res_data, res_id, last.data, last.id);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== exp_ready()) begin
      fails++;
      $display("FAIL bp_release: got %b want %b", req_ready, exp_ready());
    end
`ifndef XOR_ARBITER_FIXED_PRIO_EN
    checks++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL bp_release_rr: got %b want 0100", req_ready);
    end
`endif
    advance();
    e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e.data || res_id !== 2'(e.id)) begin
      fails++;
      $display("FAIL bp_next: got d=%h id=%0d want d=%h id=%0d",
               res_data, res_id, e.data, e.id);
    end
    req_valid = 4'b0000;
    #1;
    advance();
    advance();
    checks++;
    if (res_valid !== 1'b0 || res_data !== e.data || res_id !== 2'(e.id)) begin
      fails++;
      $display("FAIL bp_idle: got v=%b d=%h id=%0d want 0 %h %0d",
               res_valid, res_data, res_id, e.data, e.id);
    end
  endtask

  task automatic test_reset_mid();
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0102_0304;
    res_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    advance();
    e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e.data || res_id !== 2'(e.id)) begin
      fails++;
      $display("FAIL rm_load: got v=%b d=%h id=%0d want 1 %h %0d",
               res_valid, res_data, res_id, e.data, e.id);
    end
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL rm_ready: got %b want 0000", req_ready);
    end
    advance();
    checks++;
    if (res_valid !== 1'b0 || res_data !== 8'h00 || res_id !== 2'd0) begin
      fails++;
      $display("FAIL rm_clear: got v=%b d=%h id=%0d want 0 00 0",
               res_valid, res_data, res_id);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || req_ready !== exp_ready()) begin
      fails++;
      $display("FAIL rm_first: got %b want 0001", req_ready);
    end
    advance();
    e = sb.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== e.data || res_id !== 2'd0) begin
      fails++;
      $display("FAIL rm_res: got v=%b d=%h id=%0d want 1 %h 0",
               res_valid, res_data, res_id, e.data);
    end
  endtask

  task automatic test_priority();
    req_a     = 32'h7700_0011;
    req_b     = 32'h0F00_00F0;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b1001 : 4'b1000;
      #1;
      checks++;
      if (req_ready !== exp_ready()) begin
        fails++;
        $display("FAIL prio_ready%0d: got %b want %b", c, req_ready, exp_ready());
      end
      advance();
      e = sb.pop_front();
      checks++;
      if (res_valid !== 1'b1 || res_data !== e.data || res_id !== 2'(e.id)) begin
        fails++;
        $display("FAIL prio_res%0d: got d=%h id=%0d want d=%h id=%0d",
                 c, res_data, res_id, e.data, e.id);
      end
`ifdef XOR_ARBITER_FIXED_PRIO_EN
      checks++;
      if (res_id !== ((c < 4) ? 2'd0 : 2'd3)) begin
        fails++;
        $display("FAIL prio_fixed%0d: got id=%0d", c, res_id);
      end
`endif
    end
    req_valid = 4'b0000;
    #1;
    advance();
    checks++;
    if (sb.size() != 0 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL sb_empty: got size=%0d v=%b want 0 0", sb.size(), res_valid);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    m_ptr  = 0;
    m_full = 1'b0;
    loaded = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xor_arbiter.md
Name: xor_arbiter

Overview:
- Shares one WIDTH-bit XOR datapath between NUM_REQ requesters.
- The datapath is built from per-bit xor_module instances, so results stay bit-exact with the existing XOR cell.
- Per-requester valid/ready handshake on the input side; a single registered result channel with valid/ready and requester ID on the output side.
- Sits between operand producers and any consumer of XOR results.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand and result width in bits.
- ID_W, $clog2(NUM_REQ), width of res_id (derived, not overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i presents operands.
- req_ready  output  NUM_REQ  bit i: requester i's operands are accepted this cycle; at most one bit high (one-hot or zero).
- req_a  input  NUM_REQ*WIDTH  operand A; slice i is [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same slicing.
- res_valid  output  1  result register holds an unconsumed result.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  req_a[g] ^ req_b[g] of the granted requester g.
- res_id  output  ID_W  index g of the requester that produced res_data.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - res_valid=0, res_data=0, res_id=0, rr pointer=0, state=EMPTY.
  - req_ready is forced to 0 combinationally for the whole cycle rst_n is low, regardless of req_valid.
- States:
  - EMPTY: output register is free.
  - FULL: res_valid=1.
- load_en = (state==EMPTY) || res_ready. Combinational.
- Grant, round-robin (default):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit is g.
  - req_ready[g] = load_en && req_valid[g]; all other bits 0.
- Handshake:
  - A transfer occurs when req_valid[g] && req_ready[g].
  - Producers hold req_valid, req_a and req_b stable until their ready is seen.
  - The arbiter does not lock the grant across cycles; the grant is recomputed every cycle.
- On transfer (clock edge):
  - res_data <= req_a[g] ^ req_b[g]
  - res_id <= g
  - res_valid <= 1
  - ptr <= (g+1) mod NUM_REQ
- Latency: exactly 1 cycle from transfer to res_valid/res_data.
- Throughput: 1 result per cycle while res_ready=1 and any request is pending.
- Transitions:
  - EMPTY, no request -> EMPTY.
  - EMPTY, request -> FULL (load).
  - FULL, res_ready=0 -> FULL. res_data, res_id, res_valid held stable; req_ready all 0; ptr unchanged.
  - FULL, res_ready=1, request -> FULL. Previous result consumed and new result loaded on the same edge.
  - FULL, res_ready=1, no request -> EMPTY. res_valid<=0; res_data and res_id retain their last values.
- Boundaries:
  - ptr wraps from NUM_REQ-1 to 0.
  - If only requester ptr-1 is requesting, it is granted again (search wraps fully).
  - res_ready while res_valid=0 is ignored.
  - Reset mid-transaction discards the held result; the in-flight producer is not acknowledged and must re-present its operands.
- Fairness: with all requesters continuously valid and no backpressure, grants rotate 0,1,...,NUM_REQ-1,0.

Optional Feature:
- Macro: XOR_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. Lowest set index of req_valid wins; ptr is not used and not updated.
- Undefined: round-robin as described above.
- All other behaviour, ports and latency are identical in both builds.

Test Plan (NUM_REQ=4, WIDTH=8):
1. rst_n=0 for 2 cycles with req_valid=4'b1111 -> req_ready=0 every cycle; after the reset edge res_valid=0, res_data=8'h00, res_id=0.
2. Only req_valid[2]=1, a=8'hA5, b=8'h0F, res_ready=1 -> req_ready=4'b0100 in the same cycle; next cycle res_valid=1, res_data=8'hAA, res_id=2.
3. req_valid=4'b1111 held, res_ready=1, starting from ptr=0 -> res_id sequence 0,1,2,3,0 on consecutive cycles, each res_data correct.
4. FULL with res_id=1, then res_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0; res_data and res_id unchanged. Raise res_ready -> req_ready=4'b0100 the same cycle; next result has res_id=2.
5. res_valid=1 and ptr=3, pull rst_n=0 for 1 cycle, then req_valid=4'b1111 -> res_valid=0 after reset; first grant goes to 0.
6. XOR_ARBITER_FIXED_PRIO_EN defined, req_valid=4'b1001 held, res_ready=1 -> res_id=0 every cycle; requester 3 is never granted until req_valid[0]=0.
